freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 158 +++++++++++++++
 tb/tb_freq_meter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: measures the period and high time of an asynchronous periodic
// input in clk cycles. sig_in is synchronized, edges are detected, and a small
// IDLE/ARMED/MEASURE state machine counts cycles between consecutive rising
// edges. A saturated counter abandons the measurement with a timeout pulse.
module freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   sync_val;
  logic                   rise;
  logic                   fall;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [CNT_W-1:0]       ht_pend_q, ht_pend_d;
  logic                   fall_seen_q, fall_seen_d;
  logic                   valid_q, valid_d;
  logic                   at_max;

  // Synchronizer shift and edge detection against the one-cycle-delayed copy
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    sync_val = sync_q[SYNC_STAGES-1];
    dly_d    = sync_val;
    rise     = sync_val & ~dly_q;
    fall     = ~sync_val & dly_q;
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // Next-state logic: counting, capture of results and the saturation timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    ht_pend_d   = ht_pend_q;
    fall_seen_d = fall_seen_q;
    valid_d     = 1'b0;
    timeout     = 1'b0;
    at_max      = (cnt_q == CNT_MAX);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          cnt_d   = CNT_ZERO;
        end
      end

      ARMED: begin
        if (rise) begin
          state_d     = MEASURE;
          cnt_d       = CNT_ONE;
          fall_seen_d = 1'b0;
          ht_pend_d   = CNT_ZERO;
        end else if (at_max) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      MEASURE: begin
        if (rise) begin
          // Closing edge: results are published together; a missing fall
          // reports zero high time.
          period_d = cnt_q;
          high_d   = fall_seen_q ? ht_pend_q : CNT_ZERO;
          valid_d  = 1'b1;
          if (cont) begin
            cnt_d       = CNT_ONE;
            fall_seen_d = 1'b0;
            ht_pend_d   = CNT_ZERO;
          end else begin
            state_d = IDLE;
          end
        end else if (at_max) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall && !fall_seen_q) begin
            ht_pend_d   = cnt_q;
            fall_seen_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Measurement state and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      high_q      <= '0;
      ht_pend_q   <= '0;
      fall_seen_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      ht_pend_q   <= ht_pend_d;
      fall_seen_q <= fall_seen_d;
      valid_q     <= valid_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: drives identical stimulus into a 16-bit and a 4-bit counter
// instance. An edge-list reference model predicts every valid/timeout event
// (cycle, period, high_time) into per-instance queues; negedge monitors pop
// and compare whenever an instance raises valid or timeout.
module tb_freq_meter;

  localparam int SYNC = 2;
  localparam int MAXN = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;

  logic [15:0] period16, high16;
  logic        valid16, timeout16, busy16;
  logic [3:0]  period4, high4;
  logic        valid4, timeout4, busy4;

  freq_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut16 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .period(period16), .high_time(high16), .valid(valid16),
    .timeout(timeout16), .busy(busy16)
  );

  freq_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .period(period4), .high_time(high4), .valid(valid4),
    .timeout(timeout4), .busy(busy4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit is_to;
    int per;
    int hi;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lc       = -100;
  bit   lev_a[MAXN];
  bit   st_a[MAXN];
  bit   ct_a[MAXN];

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, lc);
    end
  endtask

  // Level the bench drove in cycle i; quiet before the run, held after it
  function automatic bit lev(input int i);
    if (i < 0) return 1'b0;
    if (i >= MAXN) return lev_a[MAXN-1];
    return lev_a[i];
  endfunction

  function automatic bit rise_at(input int c);
    return lev(c - SYNC) && !lev(c - SYNC - 1);
  endfunction

  function automatic bit fall_at(input int c);
    return !lev(c - SYNC) && lev(c - SYNC - 1);
  endfunction

  task automatic push_exp(input int maxv, input int n, input int cyc,
                          input bit is_to, input int per, input int hi);
    exp_t e;
    if (cyc > n - 1) return;
    e.cyc = cyc; e.is_to = is_to; e.per = per; e.hi = hi;
    if (maxv == 15) q4.push_back(e);
    else q16.push_back(e);
  endtask

  // Edge-list model: find the opening rise after arming, then the next rise,
  // and report distances; too long a gap becomes a timeout.
  task automatic run_model(input int maxv, input int n, output bit busy_end);
    int t, s, a, r0, r1, f, idle, lper, lhi;
    lper = 0; lhi = 0; t = 0; busy_end = 1'b0;
    while (t < n) begin
      s = t;
      while (s < n && !st_a[s]) s++;
      if (s >= n) break;
      a = s + 1;
      idle = -1;
      r0 = -1;
      for (int c = a; c <= a + maxv; c++) if (rise_at(c)) begin r0 = c; break; end
      if (r0 < 0) begin
        push_exp(maxv, n, a + maxv, 1'b1, lper, lhi);
        idle = a + maxv + 1;
      end
      while (idle < 0) begin
        if (r0 > n) begin idle = n + 1; break; end
        r1 = -1; f = -1;
        for (int c = r0 + 1; c <= r0 + maxv; c++) begin
          if (rise_at(c)) begin r1 = c; break; end
          if (f < 0 && fall_at(c)) f = c;
        end
        if (r1 < 0) begin
          push_exp(maxv, n, r0 + maxv, 1'b1, lper, lhi);
          idle = r0 + maxv + 1;
        end else begin
          lper = r1 - r0;
          lhi  = (f < 0) ? 0 : f - r0;
          push_exp(maxv, n, r1 + 1, 1'b0, lper, lhi);
          if (r1 < MAXN && ct_a[r1]) r0 = r1;
          else idle = r1 + 1;
        end
      end
      if (idle > n) busy_end = 1'b1;
      t = idle;
    end
  endtask

  task automatic check_event(input bit is4, input bit v, input bit to,
                             input int per, input int hi);
    exp_t  e;
    string tag;
    tag = is4 ? "dut4" : "dut16";
    if (v && to) checkOutput({tag, " valid_and_timeout_exclusive"}, 1, 0);
    if (v || to) begin
      if ((is4 && q4.size() == 0) || (!is4 && q16.size() == 0)) begin
        checkOutput({tag, " unexpected_event_cycle"}, lc, -1);
      end else begin
        if (is4) e = q4.pop_front();
        else e = q16.pop_front();
        checkOutput({tag, " event_cycle"}, lc, e.cyc);
        checkOutput({tag, " event_is_timeout"}, to, e.is_to);
        checkOutput({tag, " period"}, per, e.per);
        checkOutput({tag, " high_time"}, hi, e.hi);
      end
    end
  endtask

  // Monitor: compare whenever either instance presents a result or timeout
  always @(negedge clk) begin
    if (rst) begin
      check_event(1'b0, valid16, timeout16, int'(period16), int'(high16));
      check_event(1'b1, valid4, timeout4, int'(period4), int'(high4));
    end
  end

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " dut16 period"}, period16, 0);
    checkOutput({tag, " dut16 high_time"}, high16, 0);
    checkOutput({tag, " dut16 valid"}, valid16, 0);
    checkOutput({tag, " dut16 timeout"}, timeout16, 0);
    checkOutput({tag, " dut16 busy"}, busy16, 0);
    checkOutput({tag, " dut4 period"}, period4, 0);
    checkOutput({tag, " dut4 high_time"}, high4, 0);
    checkOutput({tag, " dut4 valid"}, valid4, 0);
    checkOutput({tag, " dut4 timeout"}, timeout4, 0);
    checkOutput({tag, " dut4 busy"}, busy4, 0);
  endtask

  task automatic clear_ctl();
    for (int k = 0; k < MAXN; k++) begin st_a[k] = 1'b0; ct_a[k] = 1'b0; end
  endtask

  task automatic gen_wave(input int p, input int h, input int ph);
    for (int k = 0; k < MAXN; k++) lev_a[k] = ((k + ph) % p) < h;
  endtask

  task automatic gen_random();
    int k, p, h, reps, len;
    k = 0;
    while (k < MAXN) begin
      if ($urandom_range(9, 0) == 0) begin
        len = $urandom_range(40, 16);
        for (int j = 0; j < len && k < MAXN; j++) begin lev_a[k] = 1'b0; k++; end
      end else begin
        p = $urandom_range(40, 2);
        h = $urandom_range(p - 1, 1);
        reps = $urandom_range(6, 1);
        for (int r = 0; r < reps; r++)
          for (int j = 0; j < p && k < MAXN; j++) begin lev_a[k] = (j < h); k++; end
      end
    end
    for (int i = 0; i < MAXN; i++) begin
      st_a[i] = ($urandom_range(9, 0) == 0);
      ct_a[i] = $urandom_range(1, 0) == 1;
    end
  endtask

  // One scenario: reset, predict, drive n cycles (optionally reset at rst_at)
  task automatic applyStimulus(input string tag, input int n, input int rst_at);
    bit b16, b4;
    int horizon;
    rst = 1'b0; sig_in = 1'b0; start = 1'b0; cont = 1'b0; lc = -100;
    repeat (3) @(posedge clk);
    q16.delete(); q4.delete();
    horizon = (rst_at >= 0) ? rst_at : n;
    run_model(65535, horizon, b16);
    run_model(15, horizon, b4);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst = 1'b1; lc = k;
      sig_in = lev_a[k]; start = st_a[k]; cont = ct_a[k];
      if (k == rst_at) begin
        rst = 1'b0; #1;
        check_all_zero({tag, " async_reset"});
        break;
      end
    end
    if (rst_at < 0) begin
      @(posedge clk); #1;
      lc = n;
      checkOutput({tag, " dut16 busy_at_end"}, busy16, b16);
      checkOutput({tag, " dut4 busy_at_end"}, busy4, b4);
    end
    checkOutput({tag, " dut16 missing_events"}, q16.size(), 0);
    checkOutput({tag, " dut4 missing_events"}, q4.size(), 0);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    check_all_zero("reset_state");

    // Divide-by-16, 50% duty, single measurement
    gen_wave(16, 8, 0); clear_ctl(); st_a[2] = 1'b1;
    applyStimulus("div16", 80, -1);

    // Divide-by-8, 25% duty, continuous for four results
    gen_wave(8, 2, 0); clear_ctl(); st_a[1] = 1'b1;
    for (int k = 0; k < 30; k++) ct_a[k] = 1'b1;
    applyStimulus("div8_cont", 60, -1);

    // Completed result, then a stalled measurement, then arming on a flat input
    for (int k = 0; k < MAXN; k++) lev_a[k] = (k < 20) && ((k % 8) < 2);
    clear_ctl(); st_a[1] = 1'b1; st_a[15] = 1'b1; st_a[40] = 1'b1;
    applyStimulus("timeout", 80, -1);

    // Rises 15 apart (largest 4-bit period), then 16 apart (4-bit timeout)
    for (int k = 0; k < MAXN; k++)
      lev_a[k] = (k >= 5 && k <= 7) || (k >= 20 && k <= 22) ||
                 (k >= 40 && k <= 42) || (k >= 56 && k <= 58);
    clear_ctl(); st_a[1] = 1'b1; st_a[30] = 1'b1;
    applyStimulus("boundary", 90, -1);

    // Reset five cycles into a measurement, then no start afterwards
    gen_wave(16, 8, 0); clear_ctl(); st_a[2] = 1'b1;
    applyStimulus("mid_reset", 40, 23);
    gen_wave(10, 5, 3); clear_ctl();
    applyStimulus("no_start", 60, -1);

    // start held high continuously
    gen_wave(12, 5, 0); clear_ctl();
    for (int k = 0; k < 60; k++) st_a[k] = 1'b1;
    applyStimulus("start_spam", 100, -1);

    for (int it = 0; it < 15; it++) begin
      gen_random();
      applyStimulus($sformatf("random%0d", it), 300, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
